spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Sequences all traffic into the SPI master engine: round-robin arbitration between NUM_REQ requesters (button/switch front end, debug port, etc.).
- Builds the 32-bit frame, handles the engine start/done handshake and returns one response per request.
- Expands global (broadcast) writes into one frame per slave, for slaves 0..NUM_SLAVES-1 in order.
- Sits between the front-end command logic and the SPI shifter/CS driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_SLAVES, 8, number of chip selects swept by a global write (1..8).
- GAP_CYCLES, 16, idle clk cycles enforced after every eng_done before the next eng_start (>=1).
- TIMEOUT_CYCLES, 65535, clk cycles allowed from eng_start to eng_done before abort.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_cmd  in  16*NUM_REQ  command word per requester, requester i at [16i+15:16i]:
  - [15] global; [14:12] slave id; [11:4] addr; [3:2] 0; [1] read; [0] 0.
- req_wdata  in  16*NUM_REQ  write data per requester.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_req  out  3  index of the requester being answered.
- rsp_rdata  out  16  read data (0 for writes and errors).
- rsp_err  out  1  response is an error (timeout or illegal global read).
- eng_start  out  1  one-cycle pulse; launches one frame.
- eng_frame  out  32  {cmd[15:0], data[15:0]}; held stable from eng_start until eng_done.
- eng_cs_idx  out  3  slave select for the frame; held with eng_frame.
- eng_busy  in  1  engine busy.
- eng_done  in  1  one-cycle pulse at frame end.
- eng_rdata  in  16  data captured by the engine; valid with eng_done.

Behaviour:
- Reset (async assert, sync release) drives the FSM to IDLE and clears outputs:
  - req_ready, rsp_valid, rsp_err, eng_start = 0; rsp_rdata, rsp_req, eng_frame, eng_cs_idx = 0.
  - Round-robin pointer resets to 0.
- Reset asserted mid-frame: eng_start stays 0. No response is emitted for the aborted request.
- IDLE:
  - Wait for any req_valid with eng_busy=0.
  - Grant the first valid requester at or after the pointer, searching upward with wrap.
  - Pulse req_ready[g] for one cycle; latch req_cmd/req_wdata; pointer <= g+1 mod NUM_REQ; go to CHECK.
- CHECK, illegal global read (global=1 and read=1): go to RESP with rsp_err=1 and no frame issued.
  - Otherwise set slave index: 0 if global, else cmd[14:12].
  - Frame data field = wdata for writes, 0 for reads; go to START.
- START: eng_start=1 for one cycle. eng_cs_idx = slave index. eng_frame[30:28] = slave index, so each broadcast frame carries its own id. Go to WAIT.
- WAIT: the timeout counter runs.
  - eng_done: capture eng_rdata if read; go to GAP.
  - Counter reaches TIMEOUT_CYCLES: set error flag; go to GAP, and mark the remaining broadcast frames as skipped.
- GAP: count GAP_CYCLES.
  - Global, not last slave, no error: slave index +1; go to START.
  - Otherwise go to RESP.
- RESP: rsp_valid=1 for one cycle with rsp_req, rsp_rdata, rsp_err; go to IDLE.
- Latency:
  - Grant to first eng_start = 2 cycles.
  - Last eng_done to rsp_valid = GAP_CYCLES+1.
- Fairness: the granted requester has lowest priority next round; a held req_valid is served again only after the others.
- No new grant until RESP completes; one transaction is in flight at most.
- eng_done seen outside WAIT is ignored.
- Slave id >= NUM_SLAVES on a single access: frame issued as given; the engine has the final say.

Optional Feature:
- SPI_ARB_STATS_EN adds outputs stat_frames (16-bit count of eng_done pulses) and stat_errs (8-bit count of rsp_err responses).
- Both counters saturate and clear on reset.
- Without the macro, neither port nor the counter logic exists.

Test Plan:
- Single write: requester 0 sends cmd 16'h11A0, wdata 16'hBEEF -> one eng_start, cs_idx=1, eng_frame=32'h11A0BEEF; rsp_valid, err=0, rdata=0.
- Single read: cmd 16'h11A2, engine returns 16'hC0DE -> eng_frame=32'h11A20000; rsp_rdata=16'hC0DE, err=0.
- Global write: cmd 16'h8050, wdata 16'hFACE -> 8 frames with cs_idx 0..7 in order, >=GAP_CYCLES idle between them; one response, err=0.
- Round robin: req 1 and 3 held valid continuously -> grants alternate 1,3,1,3; the rsp_req sequence matches.
- Errors:
  - Global read 16'h8052 -> no eng_start; rsp_err=1.
  - Engine never pulses done -> rsp_err after TIMEOUT_CYCLES+GAP_CYCLES+1 cycles.
- Reset mid-WAIT -> all outputs 0 immediately; the next request is served normally from pointer 0.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter and frame sequencer between the front-end requesters and the SPI master engine.
// Optional build macro SPI_ARB_STATS_EN adds the stat_frames / stat_errs counters.
module spi_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int NUM_SLAVES     = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_cmd,
  input  logic [16*NUM_REQ-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [2:0]            rsp_req,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  eng_start,
  output logic [31:0]           eng_frame,
  output logic [2:0]            eng_cs_idx,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic [15:0]           eng_rdata
`ifdef SPI_ARB_STATS_EN
  ,
  output logic [15:0]           stat_frames,
  output logic [7:0]            stat_errs
`endif
);

  // state | meaning
  // IDLE  | waiting for a request while the engine is free
  // CHECK | request latched, req_ready pulsed, legality and slave index decided
  // START | frame built, eng_start fires on the way to WAIT
  // WAIT  | frame in flight, timeout down-counter running
  // GAP   | enforced idle time after each frame
  // RESP  | one-cycle response strobe
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       LAST_SLV = 3'(NUM_SLAVES - 1);
  localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [15:0]      cmd_q, cmd_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [2:0]       slv_q, slv_d;
  logic             err_q, err_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [31:0]      frame_q, frame_d;
  logic [2:0]       cs_q, cs_d;

  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [15:0]      gnt_cmd;
  logic [15:0]      gnt_wdata;
  int               srch_idx;

  // First valid requester at or above the pointer, wrapping once.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_cmd   = '0;
    gnt_wdata = '0;
    srch_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      srch_idx = int'(ptr_q) + k;
      if (srch_idx >= NUM_REQ) srch_idx = srch_idx - NUM_REQ;
      if (!gnt_found && req_valid[srch_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(srch_idx);
        gnt_cmd   = req_cmd[16*srch_idx +: 16];
        gnt_wdata = req_wdata[16*srch_idx +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      wdata_q <= '0;
      slv_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      frame_q <= '0;
      cs_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      slv_q   <= slv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      frame_q <= frame_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    slv_d   = slv_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    frame_d = frame_q;
    cs_d    = cs_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found && !eng_busy) begin
          gnt_d   = gnt_idx;
          cmd_d   = gnt_cmd;
          wdata_d = gnt_wdata;
          ptr_d   = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmd_q[15] && cmd_q[1]) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          slv_d   = cmd_q[15] ? 3'd0 : cmd_q[14:12];
          state_d = S_START;
        end
      end
      S_START: begin
        // The id field is rewritten so each broadcast frame names its own slave.
        start_d = 1'b1;
        cs_d    = slv_q;
        frame_d = {cmd_q[15], slv_q, cmd_q[11:0], cmd_q[1] ? 16'h0000 : wdata_q};
        cnt_d   = TO_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_done) begin
          if (cmd_q[1]) rdata_d = eng_rdata;
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else if (cnt_q == '0) begin
          err_d   = 1'b1;
          cnt_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cmd_q[15] && !err_q && (slv_q != LAST_SLV)) begin
          slv_d   = slv_q + 3'd1;
          state_d = S_START;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == S_CHECK) ? (NUM_REQ'(1) << gnt_q) : '0;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_req    = (state_q == S_RESP) ? 3'(gnt_q) : 3'd0;
  assign rsp_rdata  = (state_q == S_RESP) ? rdata_q : 16'h0000;
  assign rsp_err    = (state_q == S_RESP) && err_q;
  assign eng_start  = start_q;
  assign eng_frame  = frame_q;
  assign eng_cs_idx = cs_q;

`ifdef SPI_ARB_STATS_EN
  logic [15:0] stat_frames_q;
  logic [7:0]  stat_errs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      if (eng_done && (stat_frames_q != 16'hFFFF)) stat_frames_q <= stat_frames_q + 16'd1;
      if (rsp_err && (stat_errs_q != 8'hFF))       stat_errs_q   <= stat_errs_q + 8'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: small engine model, event logs sampled on the falling edge,
// every expectation hand-computed for GAP_CYCLES=4 and TIMEOUT_CYCLES=30.
module tb_spi_txn_arbiter;

  localparam int NR  = 4;
  localparam int NS  = 8;
  localparam int GAP = 4;
  localparam int TO  = 30;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [16*NR-1:0] req_cmd;
  logic [16*NR-1:0] req_wdata;
  logic          rsp_valid;
  logic [2:0]    rsp_req;
  logic [15:0]   rsp_rdata;
  logic          rsp_err;
  logic          eng_start;
  logic [31:0]   eng_frame;
  logic [2:0]    eng_cs_idx;
  logic          eng_busy;
  logic          eng_done;
  logic [15:0]   eng_rdata;

  logic [15:0]   eng_val;
  bit            hang;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  logic [NR-1:0] rdy_q[$];
  int            rdy_cyc[$];
  logic [31:0]   frm_q[$];
  logic [2:0]    cs_q[$];
  int            st_cyc[$];
  logic [31:0]   done_frm[$];
  int            done_cyc[$];
  logic [2:0]    rsp_req_q[$];
  logic [15:0]   rsp_rd_q[$];
  logic          rsp_err_q[$];
  int            rsp_cyc[$];

  spi_txn_arbiter #(
    .NUM_REQ(NR), .NUM_SLAVES(NS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_req(rsp_req), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_frame(eng_frame), .eng_cs_idx(eng_cs_idx),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_rdata(eng_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_ready != '0) begin rdy_q.push_back(req_ready); rdy_cyc.push_back(cyc); end
    if (eng_start) begin
      frm_q.push_back(eng_frame); cs_q.push_back(eng_cs_idx); st_cyc.push_back(cyc);
    end
    if (eng_done) begin done_frm.push_back(eng_frame); done_cyc.push_back(cyc); end
    if (rsp_valid) begin
      rsp_req_q.push_back(rsp_req); rsp_rd_q.push_back(rsp_rdata);
      rsp_err_q.push_back(rsp_err); rsp_cyc.push_back(cyc);
    end
  end

  // Engine: done LAT cycles after the start pulse unless hung.
  initial begin
    eng_busy = 1'b0; eng_done = 1'b0; eng_rdata = '0;
    forever begin
      @(negedge clk);
      if (eng_start && !hang) begin
        eng_busy = 1'b1;
        repeat (LAT) @(posedge clk);
        #1; eng_done = 1'b1; eng_rdata = eng_val;
        @(posedge clk); #1;
        eng_done = 1'b0; eng_busy = 1'b0; eng_rdata = '0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rdy_q.delete(); rdy_cyc.delete(); frm_q.delete(); cs_q.delete(); st_cyc.delete();
    done_frm.delete(); done_cyc.delete(); rsp_req_q.delete(); rsp_rd_q.delete();
    rsp_err_q.delete(); rsp_cyc.delete();
  endtask

  task automatic issue(input int r, input logic [15:0] cmd, input logic [15:0] wd);
    int n0 = rdy_cyc.size();
    int b = 0;
    req_cmd[16*r +: 16] = cmd;
    req_wdata[16*r +: 16] = wd;
    req_valid[r] = 1'b1;
    while (rdy_cyc.size() == n0 && b < 50) begin step(1); b++; end
    req_valid[r] = 1'b0;
    check_val("grant_seen", rdy_cyc.size(), n0 + 1);
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int b = 0;
    while (rsp_cyc.size() < n && b < budget) begin step(1); b++; end
    check_val("rsp_count", rsp_cyc.size(), n);
  endtask

  initial begin
    int b;
    req_cmd = '0; req_wdata = '0; eng_val = '0; hang = 1'b0;
    req_valid = '1;
    step(3);
    check_val("rst_ready", req_ready, 0);
    check_val("rst_start", eng_start, 0);
    check_val("rst_frame", eng_frame, 0);
    check_val("rst_cs", eng_cs_idx, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    req_valid = '0;
    rst_n = 1'b1;
    step(2);

    // single write from requester 0
    clear_logs(); eng_val = 16'h5555;
    issue(0, 16'h11A0, 16'hBEEF);
    wait_rsp(1, 200);
    check_val("wr_ready", rdy_q[0], 4'b0001);
    check_val("wr_starts", st_cyc.size(), 1);
    check_val("wr_frame", frm_q[0], 32'h11A0BEEF);
    check_val("wr_cs", cs_q[0], 1);
    check_val("wr_lat_start", st_cyc[0] - rdy_cyc[0], 2);
    check_val("wr_frame_held", done_frm[0], 32'h11A0BEEF);
    check_val("wr_rsp_req", rsp_req_q[0], 0);
    check_val("wr_rsp_err", rsp_err_q[0], 0);
    check_val("wr_rsp_rdata", rsp_rd_q[0], 0);
    check_val("wr_lat_rsp", rsp_cyc[0] - done_cyc[0], GAP + 1);

    // single read from requester 2 (pointer now 1)
    clear_logs(); eng_val = 16'hC0DE;
    issue(2, 16'h11A2, 16'h7777);
    wait_rsp(1, 200);
    check_val("rd_ready", rdy_q[0], 4'b0100);
    check_val("rd_frame", frm_q[0], 32'h11A20000);
    check_val("rd_cs", cs_q[0], 1);
    check_val("rd_rsp_req", rsp_req_q[0], 2);
    check_val("rd_rsp_rdata", rsp_rd_q[0], 16'hC0DE);
    check_val("rd_rsp_err", rsp_err_q[0], 0);

    // global write from requester 0 (pointer 3 wraps to 0)
    clear_logs(); eng_val = 16'h5555;
    issue(0, 16'h8050, 16'hFACE);
    wait_rsp(1, 600);
    check_val("gw_ready", rdy_q[0], 4'b0001);
    check_val("gw_starts", st_cyc.size(), NS);
    for (int i = 0; i < NS; i++) begin
      check_val("gw_frame", frm_q[i], {16'h8050 | 16'(i << 12), 16'hFACE});
      check_val("gw_cs", cs_q[i], i);
      if (i > 0) check_val("gw_gap", st_cyc[i] - done_cyc[i-1], GAP + 2);
    end
    check_val("gw_rsp_err", rsp_err_q[0], 0);
    check_val("gw_rsp_rdata", rsp_rd_q[0], 0);
    check_val("gw_lat_rsp", rsp_cyc[0] - done_cyc[NS-1], GAP + 1);

    // round robin: 1 and 3 held valid (pointer now 1)
    clear_logs();
    req_cmd[16 +: 16] = 16'h2100; req_wdata[16 +: 16] = 16'h1111;
    req_cmd[48 +: 16] = 16'h3300; req_wdata[48 +: 16] = 16'h3333;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    wait_rsp(4, 400);
    req_valid = '0;
    step(10);
    check_val("rr_no_extra", rsp_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_val("rr_ready", rdy_q[i], (i % 2 == 0) ? 4'b0010 : 4'b1000);
      check_val("rr_rsp_req", rsp_req_q[i], (i % 2 == 0) ? 1 : 3);
    end
    check_val("rr_frame0", frm_q[0], 32'h21001111);
    check_val("rr_frame1", frm_q[1], 32'h33003333);

    // illegal global read from requester 1 (pointer now 0)
    clear_logs();
    issue(1, 16'h8052, 16'h0000);
    wait_rsp(1, 50);
    check_val("gr_ready", rdy_q[0], 4'b0010);
    check_val("gr_starts", st_cyc.size(), 0);
    check_val("gr_rsp_err", rsp_err_q[0], 1);
    check_val("gr_rsp_rdata", rsp_rd_q[0], 0);
    check_val("gr_rsp_req", rsp_req_q[0], 1);
    check_val("gr_lat", rsp_cyc[0] - rdy_cyc[0], 1);

    // engine timeout on a read from requester 3 (pointer now 2)
    clear_logs(); hang = 1'b1;
    issue(3, 16'h2012, 16'h0000);
    wait_rsp(1, 200);
    check_val("to_ready", rdy_q[0], 4'b1000);
    check_val("to_frame", frm_q[0], 32'h20120000);
    check_val("to_cs", cs_q[0], 2);
    check_val("to_rsp_err", rsp_err_q[0], 1);
    check_val("to_rsp_rdata", rsp_rd_q[0], 0);
    check_val("to_rsp_req", rsp_req_q[0], 3);
    check_val("to_lat", rsp_cyc[0] - st_cyc[0], TO + GAP + 1);

    // reset in the middle of WAIT (pointer now 0, grant goes to 2, pointer 3)
    clear_logs();
    issue(2, 16'h4400, 16'h1234);
    b = 0;
    while (st_cyc.size() == 0 && b < 20) begin step(1); b++; end
    check_val("mr_started", st_cyc.size(), 1);
    step(3);
    rst_n = 1'b0;
    #1;
    check_val("mr_frame", eng_frame, 0);
    check_val("mr_cs", eng_cs_idx, 0);
    check_val("mr_start", eng_start, 0);
    check_val("mr_ready", req_ready, 0);
    check_val("mr_rsp_valid", rsp_valid, 0);
    step(2);
    rst_n = 1'b1;
    hang = 1'b0;
    step(40);
    check_val("mr_no_rsp", rsp_cyc.size(), 0);

    // after reset the pointer is 0: with 1 and 3 valid, 1 wins
    clear_logs(); eng_val = 16'h5555;
    req_cmd[16 +: 16] = 16'h5500; req_wdata[16 +: 16] = 16'h0101;
    req_cmd[48 +: 16] = 16'h6600; req_wdata[48 +: 16] = 16'h0303;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    b = 0;
    while (rdy_cyc.size() == 0 && b < 20) begin step(1); b++; end
    req_valid = '0;
    wait_rsp(1, 200);
    check_val("pr_ready", rdy_q[0], 4'b0010);
    check_val("pr_frame", frm_q[0], 32'h55000101);
    check_val("pr_rsp_req", rsp_req_q[0], 1);
    check_val("pr_rsp_err", rsp_err_q[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got no end expected end");
    $fatal(1);
  end

endmodule
